// File: rtl/a_access_ctrl_if.sv
// Access-controller bus: request/decode side plus region-table and memsel config.
// master = requester, slave = a_access_ctrl.
interface a_access_ctrl_if #(
    parameter int N_REGION = 4,
    parameter int ADDR_W   = 24
);
    localparam int IDX_W = (N_REGION > 1) ? $clog2(N_REGION) : 1;

    logic                acc_req;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_write;
    logic                acc_ready;
    logic                acc_done;
    logic [N_REGION-1:0] region_hit;
    logic                region_miss;
    logic                rd_strobe;
    logic                wr_strobe;
    logic [1:0]          cur_speed;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [1:0]          cfg_sel;
    logic [ADDR_W-1:0]   cfg_data;
    logic                memsel_we;
    logic                memsel_d;

    modport master (
        output acc_req, acc_addr, acc_write,
        output cfg_we, cfg_idx, cfg_sel, cfg_data,
        output memsel_we, memsel_d,
        input  acc_ready, acc_done, region_hit, region_miss,
        input  rd_strobe, wr_strobe, cur_speed
    );

    modport slave (
        input  acc_req, acc_addr, acc_write,
        input  cfg_we, cfg_idx, cfg_sel, cfg_data,
        input  memsel_we, memsel_d,
        output acc_ready, acc_done, region_hit, region_miss,
        output rd_strobe, wr_strobe, cur_speed
    );
endinterface

// File: rtl/a_access_ctrl.sv
// Region-decoding bus access controller: latches decode and speed on accept,
// then runs a fixed-length access with registered done/strobe outputs.
module a_access_ctrl #(
    parameter int N_REGION  = 4,
    parameter int ADDR_W    = 24,
    parameter int LEN_FAST  = 6,
    parameter int LEN_SLOW  = 8,
    parameter int LEN_XSLOW = 12
) (
    input logic         clk,
    input logic         reset_n,
    a_access_ctrl_if.slave bus
);
    localparam logic [1:0] SP_FAST  = 2'd0;
    localparam logic [1:0] SP_SLOW  = 2'd1;
    localparam logic [1:0] SP_XSLOW = 2'd2;
    localparam logic [1:0] SP_VAR   = 2'd3;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic       memsel_q;

    logic [ADDR_W-1:0] base_q [N_REGION];
    logic [ADDR_W-1:0] mask_q [N_REGION];
    logic [1:0]        spd_q  [N_REGION];
    logic [N_REGION-1:0] en_q;

    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                rds_q, rds_d;
    logic                wrs_q, wrs_d;
    logic [N_REGION-1:0] hit_q, hit_d;
    logic                miss_q, miss_d;
    logic [1:0]          speed_q, speed_d;

    logic [N_REGION-1:0] dec_hit;
    logic [1:0]          dec_spd;
    logic                dec_found;
    logic [1:0]          res_spd;

    function automatic logic [3:0] len_m1(input logic [1:0] s);
        unique case (s)
            SP_FAST:  return 4'(LEN_FAST - 1);
            SP_SLOW:  return 4'(LEN_SLOW - 1);
            default:  return 4'(LEN_XSLOW - 1);
        endcase
    endfunction

    // Lowest matching index wins, so scan upward and stop at the first hit.
    always_comb begin
        dec_hit   = '0;
        dec_spd   = SP_FAST;
        dec_found = 1'b0;
        for (int i = 0; i < N_REGION; i++) begin
            if (!dec_found && en_q[i] &&
                ((bus.acc_addr & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
                dec_found  = 1'b1;
                dec_hit[i] = 1'b1;
                dec_spd    = spd_q[i];
            end
        end
    end

    always_comb begin
        res_spd = dec_spd;
        if (!dec_found) begin
            res_spd = SP_FAST;
        end else if (dec_spd == SP_VAR) begin
            res_spd = memsel_q ? SP_FAST : SP_SLOW;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        speed_d = speed_q;
        unique case (state_q)
            IDLE: begin
                if (bus.acc_req) begin
                    state_d = ACTIVE;
                    cnt_d   = len_m1(res_spd);
                    wr_d    = bus.acc_write;
                    hit_d   = dec_hit;
                    miss_d  = !dec_found;
                    speed_d = res_spd;
                end
            end
            ACTIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    hit_d   = '0;
                    miss_d  = 1'b0;
                    speed_d = SP_FAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered copies of the next-state view.
        ready_d = (state_d == IDLE);
        done_d  = (state_d == ACTIVE) && (cnt_d == 4'd0);
        rds_d   = (state_d == ACTIVE) && (cnt_d <= 4'd1) && !miss_d && !wr_d;
        wrs_d   = (state_d == ACTIVE) && (cnt_d <= 4'd1) && !miss_d && wr_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rds_q   <= 1'b0;
            wrs_q   <= 1'b0;
            hit_q   <= '0;
            miss_q  <= 1'b0;
            speed_q <= SP_FAST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rds_q   <= rds_d;
            wrs_q   <= wrs_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            speed_q <= speed_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memsel_q <= 1'b0;
            en_q     <= '0;
            for (int i = 0; i < N_REGION; i++) begin
                base_q[i] <= '0;
                mask_q[i] <= '0;
                spd_q[i]  <= SP_SLOW;
            end
        end else begin
            if (bus.memsel_we) begin
                memsel_q <= bus.memsel_d;
            end
            if (bus.cfg_we && (int'(bus.cfg_idx) < N_REGION)) begin
                unique case (bus.cfg_sel)
                    2'd0: base_q[bus.cfg_idx] <= bus.cfg_data;
                    2'd1: mask_q[bus.cfg_idx] <= bus.cfg_data;
                    2'd2: begin
                        en_q[bus.cfg_idx]  <= bus.cfg_data[2];
                        spd_q[bus.cfg_idx] <= bus.cfg_data[1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.acc_ready   = ready_q;
    assign bus.acc_done    = done_q;
    assign bus.rd_strobe   = rds_q;
    assign bus.wr_strobe   = wrs_q;
    assign bus.region_hit  = hit_q;
    assign bus.region_miss = miss_q;
    assign bus.cur_speed   = speed_q;
endmodule
